// File: rtl/serv_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and the
// counter wrap point as a function of the serial datapath width.
package serv_seq_pkg;

   // FSM states of the instruction-level sequencer (3-bit encoding).
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_INIT   = 3'd3,
      S_RUN    = 3'd4
   } state_t;

   // Width of the serial bit counter.
   localparam int CNT_W = 5;

   // Last counter value of a 32-bit pass: CNT_LAST = 32 - W.
   function automatic logic [CNT_W-1:0] cnt_last(input int w);
      return CNT_W'(32 - w);
   endfunction

endpackage

// File: rtl/serv_pc_seq_if.sv
// Instruction bus fetch handshake seen by the sequencer.
// cyc is raised by the master to request an instruction and held until ack;
// ack is a single-cycle strobe from the slave, only honoured while cyc = 1,
// and it marks the cycle in which the fetched instruction is valid.
interface serv_pc_seq_if;
   logic cyc;
   logic ack;

   modport master (output cyc, input ack);
   modport slave  (input cyc, output ack);
endinterface

// File: rtl/serv_seq_cnt.sv
// Serial bit counter with bit-position strobe decode for one 32-bit pass.
// Only W = 1 and W = 4 are meaningful widths.
module serv_seq_cnt
   import serv_seq_pkg::*;
#(
   parameter int W = 1
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_cnt0,
   output logic o_cnt1,
   output logic o_cnt2,
   output logic o_cnt03,
   output logic o_cnt12to31,
   output logic o_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = cnt_last(W);
   localparam logic [CNT_W-1:0] STEP     = CNT_W'(W);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on pass entry, otherwise step by W and wrap after the last position.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + STEP;
      end
   end

   // Counter register, cleared immediately by reset.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Strobes are qualified by the pass enable; with W = 4 the count only
   // takes multiples of 4, so cnt03 collapses onto cnt0 and cnt1/cnt2 never fire.
   assign o_cnt0      = i_en & (cnt_q == 5'd0);
   assign o_cnt1      = (W == 1) & i_en & (cnt_q == 5'd1);
   assign o_cnt2      = (W == 1) & i_en & (cnt_q == 5'd2);
   assign o_cnt03     = i_en & (cnt_q < 5'd4);
   assign o_cnt12to31 = i_en & (cnt_q >= 5'd12);
   assign o_done      = i_en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/serv_pc_seq.sv
// Instruction-level sequencer for the bit-serial PC datapath: runs the fetch
// handshake, steps one or two serial passes per instruction and produces the
// pc_en / jump / trap controls. The PC value itself lives in serv_ctrl.
module serv_pc_seq
   import serv_seq_pkg::*;
#(
   parameter int W        = 1,
   parameter bit WITH_CSR = 1'b1
) (
   input  logic                clk,
   input  logic                i_rst_n,
   serv_pc_seq_if.master       ibus,
   input  logic                i_two_stage,
   input  logic                i_jump_uncond,
   input  logic                i_branch_taken,
   input  logic                i_trap_req,
   output logic                o_cnt_en,
   output logic                o_init,
   output logic                o_cnt0,
   output logic                o_cnt1,
   output logic                o_cnt2,
   output logic                o_cnt03,
   output logic                o_cnt12to31,
   output logic                o_cnt_done,
   output logic                o_pc_en,
   output logic                o_jump,
   output logic                o_trap,
   output state_t              o_state
);

   state_t state_q;
   logic   cyc_q;
   logic   init_q;
   logic   run_q;
   logic   jump_q;
   logic   trap_q;

   logic   trap_now;
   logic   go_init;
   logic   cnt_done;

   // Trap request only exists when CSR support is built in.
   assign trap_now = i_trap_req & WITH_CSR;
   // A pending trap overrides the init pass: the PC is loaded straight from the CSR.
   assign go_init  = i_two_stage & ~trap_now;

   // Sequencer FSM with registered handshake, pass flags and jump/trap latches.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cyc_q   <= 1'b0;
         init_q  <= 1'b0;
         run_q   <= 1'b0;
         jump_q  <= 1'b0;
         trap_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               cyc_q   <= 1'b1;
            end
            S_FETCH: begin
               if (ibus.ack) begin
                  state_q <= S_DECODE;
                  cyc_q   <= 1'b0;
               end
            end
            S_DECODE: begin
               trap_q  <= trap_now;
               jump_q  <= i_jump_uncond & ~trap_now;
               init_q  <= go_init;
               run_q   <= ~go_init;
               state_q <= go_init ? S_INIT : S_RUN;
            end
            S_INIT: begin
               if (cnt_done) begin
                  jump_q  <= jump_q | i_branch_taken;
                  init_q  <= 1'b0;
                  run_q   <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (cnt_done) begin
                  jump_q  <= 1'b0;
                  trap_q  <= 1'b0;
                  run_q   <= 1'b0;
                  cyc_q   <= 1'b1;
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cyc_q   <= 1'b0;
               init_q  <= 1'b0;
               run_q   <= 1'b0;
               jump_q  <= 1'b0;
               trap_q  <= 1'b0;
            end
         endcase
      end
   end

   // Serial counter; restarted while decoding so every pass begins at bit 0.
   serv_seq_cnt #(.W(W)) u_cnt (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (state_q == S_DECODE),
      .i_en        (o_cnt_en),
      .o_cnt0      (o_cnt0),
      .o_cnt1      (o_cnt1),
      .o_cnt2      (o_cnt2),
      .o_cnt03     (o_cnt03),
      .o_cnt12to31 (o_cnt12to31),
      .o_done      (cnt_done)
   );

   assign ibus.cyc   = cyc_q;
   assign o_cnt_en   = init_q | run_q;
   assign o_init     = init_q;
   assign o_pc_en    = run_q;
   assign o_cnt_done = cnt_done;
   // jump may already be latched during INIT but is only presented in RUN.
   assign o_jump     = jump_q & run_q;
   // trap is latched leaving DECODE and cleared at the end of RUN.
   assign o_trap     = trap_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_serv_pc_seq.sv
// Directed bench for serv_pc_seq: three instances (W=1 with CSR, W=4 with CSR,
// W=1 without CSR) share one set of stimulus inputs; each test resets all of
// them and observes the instance it targets.
module tb_serv_pc_seq;
   import serv_seq_pkg::*;

   typedef struct packed {
      logic cyc;
      logic cnt_en;
      logic init;
      logic cnt0;
      logic cnt1;
      logic cnt2;
      logic cnt03;
      logic c12;
      logic done;
      logic pc_en;
      logic jump;
      logic trap;
   } obs_t;

   // One instruction scenario with hand-computed expected pass behaviour.
   typedef struct {
      int   sel;      // 0: W1 CSR1, 1: W4 CSR1, 2: W1 CSR0
      logic two;
      logic juc;
      logic br;
      logic trap;
      int   delay;    // cycles in FETCH before ack
      int   e_init;   // INIT cycles
      int   e_run;    // RUN cycles
      int   e_jump;   // o_jump level during RUN
      int   e_trap;   // o_trap level during RUN
      int   e_rise;   // cycles from ack to next cyc rise
      int   e_cnt0;   // cnt0 pulses over the instruction
      int   e_cnt03;  // cnt03 cycles over the instruction
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ack;
   logic two_stage;
   logic jump_uncond;
   logic branch_taken;
   logic trap_req;

   obs_t   ob1, ob4, ob0;
   state_t st1, st4, st0;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t vt[8];

   // clock / reset
   always #5 clk = ~clk;

   serv_pc_seq_if if1 ();
   serv_pc_seq_if if4 ();
   serv_pc_seq_if if0 ();
   assign if1.ack = ack;
   assign if4.ack = ack;
   assign if0.ack = ack;
   assign ob1.cyc = if1.cyc;
   assign ob4.cyc = if4.cyc;
   assign ob0.cyc = if0.cyc;

   serv_pc_seq #(.W(1), .WITH_CSR(1'b1)) dut_w1 (
      .clk(clk), .i_rst_n(rst_n), .ibus(if1.master),
      .i_two_stage(two_stage), .i_jump_uncond(jump_uncond),
      .i_branch_taken(branch_taken), .i_trap_req(trap_req),
      .o_cnt_en(ob1.cnt_en), .o_init(ob1.init), .o_cnt0(ob1.cnt0),
      .o_cnt1(ob1.cnt1), .o_cnt2(ob1.cnt2), .o_cnt03(ob1.cnt03),
      .o_cnt12to31(ob1.c12), .o_cnt_done(ob1.done), .o_pc_en(ob1.pc_en),
      .o_jump(ob1.jump), .o_trap(ob1.trap), .o_state(st1)
   );

   serv_pc_seq #(.W(4), .WITH_CSR(1'b1)) dut_w4 (
      .clk(clk), .i_rst_n(rst_n), .ibus(if4.master),
      .i_two_stage(two_stage), .i_jump_uncond(jump_uncond),
      .i_branch_taken(branch_taken), .i_trap_req(trap_req),
      .o_cnt_en(ob4.cnt_en), .o_init(ob4.init), .o_cnt0(ob4.cnt0),
      .o_cnt1(ob4.cnt1), .o_cnt2(ob4.cnt2), .o_cnt03(ob4.cnt03),
      .o_cnt12to31(ob4.c12), .o_cnt_done(ob4.done), .o_pc_en(ob4.pc_en),
      .o_jump(ob4.jump), .o_trap(ob4.trap), .o_state(st4)
   );

   serv_pc_seq #(.W(1), .WITH_CSR(1'b0)) dut_nocsr (
      .clk(clk), .i_rst_n(rst_n), .ibus(if0.master),
      .i_two_stage(two_stage), .i_jump_uncond(jump_uncond),
      .i_branch_taken(branch_taken), .i_trap_req(trap_req),
      .o_cnt_en(ob0.cnt_en), .o_init(ob0.init), .o_cnt0(ob0.cnt0),
      .o_cnt1(ob0.cnt1), .o_cnt2(ob0.cnt2), .o_cnt03(ob0.cnt03),
      .o_cnt12to31(ob0.c12), .o_cnt_done(ob0.done), .o_pc_en(ob0.pc_en),
      .o_jump(ob0.jump), .o_trap(ob0.trap), .o_state(st0)
   );

   function automatic obs_t get_obs(input int sel);
      case (sel)
         1:       return ob4;
         2:       return ob0;
         default: return ob1;
      endcase
   endfunction

   function automatic state_t get_st(input int sel);
      case (sel)
         1:       return st4;
         2:       return st0;
         default: return st1;
      endcase
   endfunction

   // scoreboard compare
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges, check the idle outputs, release just after an edge (cycle 0).
   task automatic do_reset();
      rst_n        = 1'b0;
      ack          = 1'b0;
      two_stage    = 1'b0;
      jump_uncond  = 1'b0;
      branch_taken = 1'b0;
      trap_req     = 1'b0;
      tick();
      tick();
      for (int s = 0; s < 3; s++) begin
         check($sformatf("reset_outs_%0d", s), 32'(get_obs(s)), 32'd0);
         check($sformatf("reset_state_%0d", s), 32'(get_st(s)), 32'(S_IDLE));
      end
      rst_n = 1'b1;
   endtask

   // Run one table scenario from reset through the next fetch request.
   task automatic run_vec(input int idx, input vec_t v);
      obs_t o;
      int   low, rise, found;
      int   n_init, n_run, run_j, run_t, init_pc, stray_j, c0, c03;
      do_reset();
      tick();
      check($sformatf("v%0d_fetch_cyc", idx), 32'(get_obs(v.sel).cyc), 32'd1);
      low = 0;
      repeat (v.delay) begin
         tick();
         if (!get_obs(v.sel).cyc) low++;
      end
      check($sformatf("v%0d_cyc_held", idx), low, 0);
      ack = 1'b1;
      tick();
      ack          = 1'b0;
      two_stage    = v.two;
      jump_uncond  = v.juc;
      trap_req     = v.trap;
      branch_taken = v.br;
      check($sformatf("v%0d_decode", idx), 32'(get_st(v.sel)), 32'(S_DECODE));
      rise = 1; found = 0;
      n_init = 0; n_run = 0; run_j = 0; run_t = 0; init_pc = 0; stray_j = 0; c0 = 0; c03 = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         tick();
         rise++;
         o = get_obs(v.sel);
         if (o.cyc) begin
            found = 1;
            check($sformatf("v%0d_jump_in_fetch", idx), 32'(o.jump), 32'd0);
            check($sformatf("v%0d_pc_en_in_fetch", idx), 32'(o.pc_en), 32'd0);
         end else begin
            if (o.init) n_init++;
            if (o.init && o.pc_en) init_pc++;
            if (o.pc_en) begin
               n_run++;
               if (o.jump) run_j++;
               if (o.trap) run_t++;
            end else if (o.jump) begin
               stray_j++;
            end
            if (o.cnt0) c0++;
            if (o.cnt03) c03++;
         end
      end
      two_stage = 1'b0; jump_uncond = 1'b0; trap_req = 1'b0; branch_taken = 1'b0;
      check($sformatf("v%0d_cyc_rose_in_budget", idx), found, 1);
      check($sformatf("v%0d_rise_cycle", idx), rise, v.e_rise);
      check($sformatf("v%0d_init_cycles", idx), n_init, v.e_init);
      check($sformatf("v%0d_run_cycles", idx), n_run, v.e_run);
      check($sformatf("v%0d_jump_cycles", idx), run_j, v.e_jump * v.e_run);
      check($sformatf("v%0d_trap_cycles", idx), run_t, v.e_trap * v.e_run);
      check($sformatf("v%0d_pc_en_in_init", idx), init_pc, 0);
      check($sformatf("v%0d_jump_outside_run", idx), stray_j, 0);
      check($sformatf("v%0d_cnt0_pulses", idx), c0, v.e_cnt0);
      check($sformatf("v%0d_cnt03_cycles", idx), c03, v.e_cnt03);
   endtask

   initial begin
      obs_t o;
      logic [6:0] exp7;
      int r;

      //          sel two juc br trap dly init run jmp trp rise c0 c03
      vt[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 32, 0, 0, 34, 1, 4};
      vt[1] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 0,  8,  8, 1, 0, 18, 2, 2};
      vt[2] = '{1, 1'b1, 1'b1, 1'b1, 1'b1, 0,  0,  8, 0, 1, 10, 1, 1};
      vt[3] = '{2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32, 32, 1, 0, 66, 2, 8};
      vt[4] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 5,  0, 32, 1, 0, 34, 1, 4};
      vt[5] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32, 32, 0, 0, 66, 2, 8};
      vt[6] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 3,  0,  8, 1, 0, 10, 1, 1};
      vt[7] = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0, 32, 0, 1, 34, 1, 4};

      for (int i = 0; i < 8; i++) begin
         run_vec(i, vt[i]);
      end

      // Cycle-exact W=1 single-stage instruction, ack in cycle 3.
      do_reset();
      tick(); tick(); tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("w1_exact_decode_c4", 32'(st1), 32'(S_DECODE));
      for (int c = 5; c <= 37; c++) begin
         tick();
         exp7 = {c == 37, c >= 5 && c <= 36, c == 5, c == 6, c == 7, c >= 17 && c <= 36, c == 36};
         check($sformatf("w1_exact_c%0d", c),
               32'({ob1.cyc, ob1.pc_en, ob1.cnt0, ob1.cnt1, ob1.cnt2, ob1.c12, ob1.done}),
               32'(exp7));
      end

      // Reset asserted in RUN at cnt = 17 (W=1, jal).
      do_reset();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      jump_uncond = 1'b1;
      tick();
      check("rst_mid_run_start_cnt0", 32'(ob1.cnt0), 32'd1);
      repeat (17) tick();
      check("rst_mid_pre_state", 32'({ob1.pc_en, ob1.c12, ob1.jump, ob1.cnt0}), 32'b1110);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs_zero", 32'(ob1), 32'd0);
      check("rst_mid_state_idle", 32'(st1), 32'(S_IDLE));
      jump_uncond = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_mid_refetch", 32'({ob1.cyc, ob1.pc_en, ob1.jump}), 32'b100);
      check("rst_mid_refetch_state", 32'(st1), 32'(S_FETCH));
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      check("rst_mid_restart_cnt0", 32'({ob1.pc_en, ob1.cnt0, ob1.jump}), 32'b110);

      // W=4: ack held across FETCH->DECODE->RUN, spurious ack in RUN, ack delayed afterwards.
      do_reset();
      tick();
      repeat (5) tick();
      check("hold_cyc_before_ack", 32'(ob4.cyc), 32'd1);
      ack = 1'b1;
      tick();
      check("hold_decode", 32'({ob4.cyc, 1'b0}) | 32'(st4), 32'(S_DECODE));
      tick();
      check("hold_run", 32'(st4), 32'(S_RUN));
      check("hold_run_cyc_low", 32'(ob4.cyc), 32'd0);
      ack = 1'b0;
      tick(); tick();
      ack = 1'b1;
      tick();
      check("spur_run_1", 32'(st4), 32'(S_RUN));
      tick();
      check("spur_run_2", 32'(st4), 32'(S_RUN));
      ack = 1'b0;
      r = 6;
      for (int k = 0; k < 40 && !ob4.cyc; k++) begin
         tick();
         r++;
      end
      check("spur_rise_cycle", r, 10);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("spur_cyc_held_%0d", k), 32'({ob4.cyc, st4}), 32'({1'b1, S_FETCH}));
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("spur_real_ack_decode", 32'(st4), 32'(S_DECODE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

endmodule
